fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall priority and the
// IF/ID pipeline register, plus a counter of instructions accepted into IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_IF,
    output logic [31:0] pc_ID,
    output logic [31:0] pc_plus4_ID,
    output logic [31:0] instruction_ID,
    output logic        valid_ID,
    output logic [31:0] fetch_count
);

    // PC held as a word index so the two byte-offset bits are always zero.
    logic [29:0] r_pc_word;
    logic [29:0] r_pc_id_word;
    logic [31:0] r_instr_id;
    logic        r_valid_id;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc;
    logic [29:0] w_pc_word_plus1;
    logic        w_unused_target_bits;

    assign w_pc                 = {r_pc_word, 2'b00};
    assign w_pc_word_plus1      = r_pc_word + 30'd1;
    assign w_unused_target_bits = ^redirect_target[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_word     <= RESET_PC[31:2];
            r_pc_id_word  <= 30'd0;
            r_instr_id    <= NOP_INSTR;
            r_valid_id    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            // Redirect beats stall: squash the wrong-path word in IF/ID.
            r_pc_word    <= redirect_target[31:2];
            r_pc_id_word <= 30'd0;
            r_instr_id   <= NOP_INSTR;
            r_valid_id   <= 1'b0;
        end else if (!stall) begin
            r_pc_word     <= w_pc_word_plus1;
            r_pc_id_word  <= r_pc_word;
            r_instr_id    <= imem_rdata;
            r_valid_id    <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr      = w_pc;
    assign pc_out         = w_pc;
    assign instruction_IF = imem_rdata;
    assign pc_ID          = {r_pc_id_word, 2'b00};
    // Wraps naturally, so a flushed/reset IF/ID (pc_ID = 0) reads back 4.
    assign pc_plus4_ID    = {r_pc_id_word + 30'd1, 2'b00};
    assign instruction_ID = r_instr_id;
    assign valid_ID       = r_valid_id;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of per-edge vectors fed through a
// scoreboard queue, plus hand-written async-reset sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_IF;
    logic [31:0] pc_ID;
    logic [31:0] pc_plus4_ID;
    logic [31:0] instruction_ID;
    logic        valid_ID;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory model: each word reads as its address plus 0x100.
    assign imem_rdata = imem_addr + 32'h100;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_IF  (instruction_IF),
        .pc_ID           (pc_ID),
        .pc_plus4_ID     (pc_plus4_ID),
        .instruction_ID  (instruction_ID),
        .valid_ID        (valid_ID),
        .fetch_count     (fetch_count)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] pc_id;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc_id;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[13];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_state(input exp_t e);
        chk({e.name, ".pc_out"},         pc_out,         e.pc);
        chk({e.name, ".imem_addr"},      imem_addr,      e.pc);
        chk({e.name, ".instruction_IF"}, instruction_IF, e.pc + 32'h100);
        chk({e.name, ".pc_ID"},          pc_ID,          e.pc_id);
        chk({e.name, ".pc_plus4_ID"},    pc_plus4_ID,    e.pc4);
        chk({e.name, ".instruction_ID"}, instruction_ID, e.instr);
        chk({e.name, ".valid_ID"},       {31'd0, valid_ID}, {31'd0, e.valid});
        chk({e.name, ".fetch_count"},    fetch_count,    e.cnt);
        $display("txn %s: pc=%h pc_ID=%h instr_ID=%h valid=%0b count=%0d",
                 e.name, pc_out, pc_ID, instruction_ID, valid_ID, fetch_count);
    endtask

    function automatic exp_t mk(input string n, input logic [31:0] pc, input logic [31:0] pc_id,
                                input logic [31:0] pc4, input logic [31:0] instr,
                                input logic v, input logic [31:0] cnt);
        exp_t e;
        e.name = n; e.pc = pc; e.pc_id = pc_id; e.pc4 = pc4;
        e.instr = instr; e.valid = v; e.cnt = cnt;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        //                stall redir target          pc            pc_id         pc4           instr         v  cnt
        vecs[0]  = '{1'b0, 1'b0, 32'h0,          32'h4,        32'h0,        32'h4,        32'h100,      1'b1, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,          32'h8,        32'h4,        32'h8,        32'h104,      1'b1, 32'd2};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,          32'h8,        32'h4,        32'h8,        32'h104,      1'b1, 32'd2};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,          32'h8,        32'h4,        32'h8,        32'h104,      1'b1, 32'd2};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,          32'h8,        32'h4,        32'h8,        32'h104,      1'b1, 32'd2};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,          32'hC,        32'h8,        32'hC,        32'h108,      1'b1, 32'd3};
        vecs[6]  = '{1'b0, 1'b1, 32'h43,         32'h40,       32'h0,        32'h4,        NOP,          1'b0, 32'd3};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,          32'h44,       32'h40,       32'h44,       32'h140,      1'b1, 32'd4};
        vecs[8]  = '{1'b1, 1'b1, 32'h80,         32'h80,       32'h0,        32'h4,        NOP,          1'b0, 32'd4};
        vecs[9]  = '{1'b0, 1'b1, 32'h201,        32'h200,      32'h0,        32'h4,        NOP,          1'b0, 32'd4};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFC, 32'h0,       32'h4,        NOP,          1'b0, 32'd4};
        vecs[11] = '{1'b0, 1'b0, 32'h0,          32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0000_00FC, 1'b1, 32'd5};
        vecs[12] = '{1'b0, 1'b0, 32'h0,          32'h4,        32'h0,        32'h4,        32'h100,      1'b1, 32'd6};

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        #2;
        check_state(mk("reset", 32'h0, 32'h0, 32'h4, NOP, 1'b0, 32'd0));
        // Stall/redirect while reset is high must be ignored across an edge.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300;
        @(posedge clk); #1;
        check_state(mk("reset_hold", 32'h0, 32'h0, 32'h4, NOP, 1'b0, 32'd0));
        stall = 1'b0; redirect_valid = 1'b0;
        #2 reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            stall           = vecs[i].stall;
            redirect_valid  = vecs[i].redir;
            redirect_target = vecs[i].target;
            sbq.push_back(mk($sformatf("vec%0d", i), vecs[i].pc, vecs[i].pc_id, vecs[i].pc4,
                             vecs[i].instr, vecs[i].valid, vecs[i].cnt));
            @(posedge clk); #1;
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                e = sbq.pop_front();
                check_state(e);
            end
        end

        // Async reset mid-cycle with a pending stall+redirect, valid_ID=1, count=6.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h500;
        #2 reset = 1'b1;
        #1;
        check_state(mk("async_reset", 32'h0, 32'h0, 32'h4, NOP, 1'b0, 32'd0));
        @(posedge clk); #1;
        check_state(mk("async_reset_edge", 32'h0, 32'h0, 32'h4, NOP, 1'b0, 32'd0));
        stall = 1'b0; redirect_valid = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check_state(mk("first_fetch", 32'h4, 32'h0, 32'h4, 32'h100, 1'b1, 32'd1));
        @(posedge clk); #1;
        check_state(mk("second_fetch", 32'h8, 32'h4, 32'h8, 32'h104, 1'b1, 32'd2));

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
